// File: rtl/stepper_phase_sequencer.sv
// Stepper motor phase sequencer: runs a counted move of full or half steps at a fixed
// step period, drives a registered 4-coil pattern and tracks signed absolute position.
module stepper_phase_sequencer #(
  parameter int unsigned COUNT_W  = 16,
  parameter int unsigned PERIOD_W = 24
) (
  input  logic                clk_clk,
  input  logic                reset_reset_n,
  input  logic                start_i,
  input  logic                stop_i,
  input  logic                dir_i,
  input  logic                half_i,
  input  logic                hold_i,
  input  logic [COUNT_W-1:0]  steps_i,
  input  logic [PERIOD_W-1:0] period_i,
  output logic [3:0]          coil_o,
  output logic                busy_o,
  output logic                done_o,
  output logic [15:0]         pos_o,
  output logic [COUNT_W-1:0]  remaining_o
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]          state_q, state_d;
  logic [2:0]          phase_q, phase_d;
  logic [15:0]         pos_q, pos_d;
  logic [COUNT_W-1:0]  remaining_q, remaining_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic [PERIOD_W-1:0] per_cnt_q, per_cnt_d;
  logic                dir_q, dir_d;
  logic                half_q, half_d;
  logic [3:0]          coil_q, coil_d;
  logic [2:0]          step_inc;

  // Coil pattern {B',A',B,A} for each of the eight half-step phases.
  function automatic logic [3:0] coil_lut(input logic [2:0] ph);
    logic [3:0] c;
    unique case (ph)
      3'd0: c = 4'b0001;
      3'd1: c = 4'b0011;
      3'd2: c = 4'b0010;
      3'd3: c = 4'b0110;
      3'd4: c = 4'b0100;
      3'd5: c = 4'b1100;
      3'd6: c = 4'b1000;
      3'd7: c = 4'b1001;
      default: c = 4'b0000;
    endcase
    return c;
  endfunction

  assign step_inc = half_q ? 3'd1 : 3'd2;

  // Next-state: move start/latch, period countdown, stepping and abort.
  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    pos_d       = pos_q;
    remaining_d = remaining_q;
    period_d    = period_q;
    per_cnt_d   = per_cnt_q;
    dir_d       = dir_q;
    half_d      = half_q;
    unique case (state_q)
      StIdle: begin
        if (start_i && !stop_i) begin
          dir_d       = dir_i;
          half_d      = half_i;
          // A period below 2 would leave no room for the reload cycle.
          period_d    = (period_i < PERIOD_W'(2)) ? PERIOD_W'(2) : period_i;
          per_cnt_d   = period_d - PERIOD_W'(1);
          remaining_d = steps_i;
          state_d     = (steps_i == '0) ? StDone : StRun;
        end
      end
      StRun: begin
        if (stop_i) begin
          // Abort wins over a coincident period expiry.
          state_d = StIdle;
        end else if (per_cnt_q == '0) begin
          per_cnt_d   = period_q - PERIOD_W'(1);
          phase_d     = dir_q ? (phase_q + step_inc) : (phase_q - step_inc);
          pos_d       = dir_q ? (pos_q + 16'd1) : (pos_q - 16'd1);
          remaining_d = remaining_q - COUNT_W'(1);
          if (remaining_q == COUNT_W'(1)) state_d = StDone;
        end else begin
          per_cnt_d = per_cnt_q - PERIOD_W'(1);
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Coil drive lags the phase index by one cycle; de-energised when idle without hold.
  always_comb begin
    coil_d = 4'b0000;
    if (state_q == StRun || hold_i) coil_d = coil_lut(phase_q);
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      state_q     <= StIdle;
      phase_q     <= 3'd0;
      pos_q       <= 16'd0;
      remaining_q <= '0;
      period_q    <= '0;
      per_cnt_q   <= '0;
      dir_q       <= 1'b0;
      half_q      <= 1'b0;
      coil_q      <= 4'b0000;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      pos_q       <= pos_d;
      remaining_q <= remaining_d;
      period_q    <= period_d;
      per_cnt_q   <= per_cnt_d;
      dir_q       <= dir_d;
      half_q      <= half_d;
      coil_q      <= coil_d;
    end
  end

  assign coil_o      = coil_q;
  assign busy_o      = (state_q == StRun);
  assign done_o      = (state_q == StDone);
  assign pos_o       = pos_q;
  assign remaining_o = remaining_q;

endmodule

// File: tb/tb_stepper_phase_sequencer.sv
// Directed bench for stepper_phase_sequencer: table of complete moves checked cycle by
// cycle, plus hand-written abort, stop/expiry collision, start+stop and mid-move reset.
// Cycle numbering: cycle 0 is the cycle in which start_i is high.
module tb_stepper_phase_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_i, stop_i, dir_i, half_i, hold_i;
  logic [15:0] steps_i;
  logic [23:0] period_i;
  logic [3:0]  coil_o;
  logic        busy_o, done_o;
  logic [15:0] pos_o, remaining_o;

  int checks = 0;
  int failures = 0;

  stepper_phase_sequencer #(.COUNT_W(16), .PERIOD_W(24)) dut (
    .clk_clk       (clk),
    .reset_reset_n (rst_n),
    .start_i       (start_i),
    .stop_i        (stop_i),
    .dir_i         (dir_i),
    .half_i        (half_i),
    .hold_i        (hold_i),
    .steps_i       (steps_i),
    .period_i      (period_i),
    .coil_o        (coil_o),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .pos_o         (pos_o),
    .remaining_o   (remaining_o)
  );

  always #5 clk = ~clk;

  logic [3:0] coil_tbl [8] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110,
                               4'b0100, 4'b1100, 4'b1000, 4'b1001};

  typedef struct {
    logic        dir;
    logic        half;
    logic        hold;
    logic [15:0] steps;
    logic [23:0] period;
    int          eff_per;   // clamped period
    int          exp_pos;   // final position from phase 0 / pos 0
    logic [3:0]  exp_coil;  // final idle coil pattern
  } vec_t;

  localparam int NV = 6;
  vec_t vecs [NV];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int phase_after(input logic dir, input logic half, input int n);
    int d;
    d = (n * (half ? 1 : 2)) % 8;
    return dir ? d : (8 - d) % 8;
  endfunction

  task automatic do_reset();
    rst_n   = 1'b0;
    start_i = 1'b0;
    stop_i  = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  int   last, nv, np, tstep;
  logic run_prev, seen_done;
  logic [3:0] ecoil;

  initial begin
    rst_n = 1'b0; start_i = 1'b0; stop_i = 1'b0; dir_i = 1'b0; half_i = 1'b0;
    hold_i = 1'b0; steps_i = '0; period_i = '0;

    vecs[0] = '{1'b1, 1'b1, 1'b1, 16'd4, 24'd10, 10,  4, 4'b0100}; // fwd half
    vecs[1] = '{1'b0, 1'b0, 1'b1, 16'd3, 24'd4,  4,  -3, 4'b0010}; // rev full
    vecs[2] = '{1'b1, 1'b0, 1'b1, 16'd3, 24'd0,  2,  3, 4'b1000}; // period 0 clamp
    vecs[3] = '{1'b1, 1'b1, 1'b0, 16'd2, 24'd1,  2,  2, 4'b0000}; // period 1 clamp
    vecs[4] = '{1'b1, 1'b0, 1'b1, 16'd0, 24'd7,  7,  0, 4'b0001}; // zero steps
    vecs[5] = '{1'b0, 1'b1, 1'b1, 16'd2, 24'd3,  3, -2, 4'b1000}; // rev half wrap

    // Reset state
    tick();
    chk("reset_coil", 16'(coil_o), 16'h0);
    chk("reset_busy", 16'(busy_o), 16'h0);
    chk("reset_done", 16'(done_o), 16'h0);
    chk("reset_pos", pos_o, 16'h0);
    chk("reset_rem", remaining_o, 16'h0);

    // Table of complete moves, each from reset (phase 0, pos 0)
    for (int vi = 0; vi < NV; vi++) begin
      do_reset();
      dir_i = vecs[vi].dir; half_i = vecs[vi].half; hold_i = vecs[vi].hold;
      steps_i = vecs[vi].steps; period_i = vecs[vi].period;
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      tstep = int'(vecs[vi].steps) * vecs[vi].eff_per;
      last  = tstep + 3;
      for (int c = 1; c <= last; c++) begin
        // Step k is taken in cycle k*period, visible from the next cycle.
        nv = (c - 1) / vecs[vi].eff_per;
        if (nv > int'(vecs[vi].steps)) nv = int'(vecs[vi].steps);
        np = (c >= 2) ? (c - 2) / vecs[vi].eff_per : 0;
        if (np > int'(vecs[vi].steps)) np = int'(vecs[vi].steps);
        run_prev = (c - 1 >= 1) && (c - 1 <= tstep);
        ecoil = (run_prev || vecs[vi].hold) ?
                coil_tbl[phase_after(vecs[vi].dir, vecs[vi].half, np)] : 4'b0000;
        chk($sformatf("v%0d_c%0d_busy", vi, c), 16'(busy_o), 16'(c <= tstep));
        chk($sformatf("v%0d_c%0d_done", vi, c), 16'(done_o), 16'(c == tstep + 1));
        chk($sformatf("v%0d_c%0d_pos", vi, c), pos_o,
            16'(vecs[vi].dir ? nv : -nv));
        chk($sformatf("v%0d_c%0d_rem", vi, c), remaining_o,
            16'(int'(vecs[vi].steps) - nv));
        chk($sformatf("v%0d_c%0d_coil", vi, c), 16'(coil_o), 16'(ecoil));
        tick();
      end
      chk($sformatf("v%0d_final_pos", vi), pos_o, 16'(vecs[vi].exp_pos));
      chk($sformatf("v%0d_final_coil", vi), 16'(coil_o), 16'(vecs[vi].exp_coil));
    end

    // Abort at cycle 23 of a 100-step move with period 5; inputs wiggled mid-move.
    do_reset();
    dir_i = 1'b1; half_i = 1'b1; hold_i = 1'b0; steps_i = 16'd100; period_i = 24'd5;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    seen_done = 1'b0;
    for (int c = 1; c < 23; c++) begin
      if (c == 7) begin dir_i = 1'b0; half_i = 1'b0; period_i = 24'd1; end
      start_i = (c == 12);
      steps_i = (c == 12) ? 16'd0 : 16'd100;
      seen_done |= done_o;
      tick();
    end
    start_i = 1'b0;
    stop_i = 1'b1;  // cycle 23
    tick();
    stop_i = 1'b0;  // cycle 24
    chk("abort_busy", 16'(busy_o), 16'h0);
    chk("abort_pos", pos_o, 16'd4);
    chk("abort_rem", remaining_o, 16'd96);
    for (int c = 0; c < 6; c++) begin
      seen_done |= done_o;
      tick();
    end
    chk("abort_no_done", 16'(seen_done), 16'h0);
    chk("abort_coil_off", 16'(coil_o), 16'h0);
    hold_i = 1'b1;  // phase 4 must have been retained
    tick();
    tick();
    chk("abort_phase_kept", 16'(coil_o), 16'(4'b0100));

    // Stop in the same cycle as a period expiry: only the cycle-5 step is taken.
    do_reset();
    dir_i = 1'b1; half_i = 1'b1; hold_i = 1'b1; steps_i = 16'd10; period_i = 24'd5;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    for (int c = 1; c < 10; c++) tick();
    stop_i = 1'b1;  // cycle 10
    tick();
    stop_i = 1'b0;
    chk("collide_busy", 16'(busy_o), 16'h0);
    chk("collide_pos", pos_o, 16'd1);
    chk("collide_rem", remaining_o, 16'd9);
    chk("collide_done", 16'(done_o), 16'h0);

    // Start together with stop in IDLE is ignored.
    start_i = 1'b1; stop_i = 1'b1; steps_i = 16'd5;
    tick();
    start_i = 1'b0; stop_i = 1'b0;
    chk("startstop_busy", 16'(busy_o), 16'h0);
    chk("startstop_rem", remaining_o, 16'd9);
    tick();
    chk("startstop_busy2", 16'(busy_o), 16'h0);
    chk("startstop_done2", 16'(done_o), 16'h0);

    // Reset mid-move, with start_i high in the reset cycle.
    dir_i = 1'b1; half_i = 1'b1; hold_i = 1'b1; steps_i = 16'd10; period_i = 24'd3;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    for (int c = 1; c < 8; c++) tick();
    chk("midrst_pre_pos", pos_o, 16'd3);  // 1 from before + steps at cycles 3 and 6
    rst_n = 1'b0; start_i = 1'b1;         // cycle 8
    tick();
    rst_n = 1'b1; start_i = 1'b0;
    chk("midrst_pos", pos_o, 16'h0);
    chk("midrst_rem", remaining_o, 16'h0);
    chk("midrst_busy", 16'(busy_o), 16'h0);
    chk("midrst_done", 16'(done_o), 16'h0);
    chk("midrst_coil", 16'(coil_o), 16'h0);
    seen_done = 1'b0;
    for (int c = 0; c < 4; c++) begin
      seen_done |= done_o | busy_o;
      tick();
    end
    chk("midrst_no_activity", 16'(seen_done), 16'h0);
    chk("midrst_hold_coil", 16'(coil_o), 16'(4'b0001));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
